bht: RTL and testbench

Branch history table at the write end of the branch unit's BHT update interface. Holds 512 sets of four 2-bit saturating counters, one counter per 4-byte instruction slot in a 16-byte fetch block. Applies inc/dec updates from the branch scoreboard. Serves registered predictions to the fetch-side BPU. After reset it self-initialises every counter to weakly-not-taken before accepting traffic.

---
 rtl/bht_pkg.sv | 8 +
 rtl/bht_sat_ctr2.sv | 13 +
 rtl/bht.sv | 93 +++++++++
 tb/tb_bht.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/bht_pkg.sv
// bht_pkg: shared constants and state encoding for the branch history table.
package bht_pkg;
    localparam int BHT_SETS = 512;
    localparam int BHT_INDEX_WIDTH = 9;
    localparam int BHT_CTR_WIDTH = 2;
    localparam logic [BHT_CTR_WIDTH-1:0] BHT_CTR_INIT = 2'b01;
    typedef enum logic {INIT, READY} bht_state_t;
endpackage

// File: rtl/bht_sat_ctr2.sv
// sat_ctr2: combinational 2-bit saturating counter update.
module sat_ctr2
    import bht_pkg::*;
(
    input  logic [BHT_CTR_WIDTH-1:0] ctr,
    input  logic                     inc,
    input  logic                     dec,
    output logic [BHT_CTR_WIDTH-1:0] next
);
    always_comb
        next = (inc && !dec && ctr != 2'b11) ? ctr + 2'd1 :
               (dec && !inc && ctr != 2'b00) ? ctr - 2'd1 : ctr;
endmodule

// File: rtl/bht.sv
// bht: 512x4 2-bit counter branch history table with self-init and write-first read bypass.
module bht
    import bht_pkg::*;
#(
    parameter int SETS = BHT_SETS,
    parameter int INDEX_WIDTH = BHT_INDEX_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   bjusb2bht_write_enable,
    input  logic                   bjusb2bht_valid_in,
    input  logic [INDEX_WIDTH-1:0] bjusb2bht_write_index,
    input  logic [1:0]             bjusb2bht_write_counter_select,
    input  logic                   bjusb2bht_write_inc,
    input  logic                   bjusb2bht_write_dec,
    input  logic                   bpu2bht_read_enable,
    input  logic [INDEX_WIDTH-1:0] bpu2bht_read_index,
    output logic                   bht2bpu_read_valid,
    output logic [7:0]             bht2bpu_read_counters,
    output logic [3:0]             bht2bpu_predict_taken,
    output logic                   bht_ready
);
    localparam logic [7:0] ROW_INIT = {4{BHT_CTR_INIT}};
    localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(SETS - 1);

    bht_state_t state, state_nxt;
    logic [INDEX_WIDTH-1:0] init_ptr;
    logic [7:0] mem [SETS];
    logic [7:0] cur_row, upd_row;
    logic [1:0] cur_ctr, nxt_ctr;
    logic upd, rd, wr_en;
    logic [INDEX_WIDTH-1:0] wr_addr;
    logic [7:0] wr_data;

    assign bht_ready = state == READY;
    assign upd = bht_ready && bjusb2bht_write_enable && bjusb2bht_valid_in;
    assign rd = bht_ready && bpu2bht_read_enable;
    assign cur_row = mem[bjusb2bht_write_index];
    assign cur_ctr = cur_row[{bjusb2bht_write_counter_select, 1'b0} +: 2];

    sat_ctr2 u_sat (
        .ctr (cur_ctr),
        .inc (bjusb2bht_write_inc),
        .dec (bjusb2bht_write_dec),
        .next(nxt_ctr)
    );

    always_comb begin
        upd_row = cur_row;
        upd_row[{bjusb2bht_write_counter_select, 1'b0} +: 2] = nxt_ctr;
    end

    // Init sweep and updates share the single write port.
    assign wr_en = !bht_ready || upd;
    assign wr_addr = bht_ready ? bjusb2bht_write_index : init_ptr;
    assign wr_data = bht_ready ? upd_row : ROW_INIT;

    always_comb begin
        state_nxt = state;
        if (state == INIT && init_ptr == LAST)
            state_nxt = READY;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
            init_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT)
                init_ptr <= init_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock)
        if (wr_en)
            mem[wr_addr] <= wr_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bht2bpu_read_valid <= 1'b0;
            bht2bpu_read_counters <= '0;
        end else begin
            bht2bpu_read_valid <= rd;
            if (rd)
                bht2bpu_read_counters <= (upd && bjusb2bht_write_index == bpu2bht_read_index)
                                         ? upd_row : mem[bpu2bht_read_index];
        end
    end

    assign bht2bpu_predict_taken = {bht2bpu_read_counters[7], bht2bpu_read_counters[5],
                                    bht2bpu_read_counters[3], bht2bpu_read_counters[1]};
endmodule

// File: tb/tb_bht.sv
// tb_bht: directed self-checking bench for the branch history table.
module tb_bht;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       we = 1'b0, vin = 1'b0, inc = 1'b0, dec = 1'b0, re = 1'b0;
    logic [8:0] widx = '0, ridx = '0;
    logic [1:0] sel = '0;
    logic       read_valid, ready;
    logic [7:0] counters;
    logic [3:0] predict;
    int checks = 0, failures = 0, seen_valid = 0;

    bht dut (
        .clock(clock),
        .reset_n(reset_n),
        .bjusb2bht_write_enable(we),
        .bjusb2bht_valid_in(vin),
        .bjusb2bht_write_index(widx),
        .bjusb2bht_write_counter_select(sel),
        .bjusb2bht_write_inc(inc),
        .bjusb2bht_write_dec(dec),
        .bpu2bht_read_enable(re),
        .bpu2bht_read_index(ridx),
        .bht2bpu_read_valid(read_valid),
        .bht2bpu_read_counters(counters),
        .bht2bpu_predict_taken(predict),
        .bht_ready(ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_wr(input logic [8:0] i, input logic [1:0] s, input logic n, input logic d,
                          input logic w, input logic v);
        widx = i; sel = s; inc = n; dec = d; we = w; vin = v;
    endtask

    task automatic wr(input logic [8:0] i, input logic [1:0] s, input logic n, input logic d,
                      input logic w, input logic v);
        set_wr(i, s, n, d, w, v);
        tick();
        set_wr('0, '0, 0, 0, 0, 0);
    endtask

    task automatic check_read(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(read_valid), 32'd1);
        check({tag, "_ctr"}, 32'(counters), 32'(exp));
        check({tag, "_pred"}, 32'(predict), 32'({exp[7], exp[5], exp[3], exp[1]}));
    endtask

    task automatic rd(input string tag, input logic [8:0] i, input logic [7:0] exp);
        re = 1'b1; ridx = i;
        tick();
        re = 1'b0;
        check_read(tag, exp);
        tick();
        check({tag, "_pulse"}, 32'(read_valid), 32'd0);
        check({tag, "_hold"}, 32'(counters), 32'(exp));
    endtask

    // Runs init edges with reads requested throughout; optionally posts an update to set 9 at cycle 100.
    task automatic run_init(input int edges, input bit poke);
        seen_valid = 0;
        re = 1'b1; ridx = 9'd9;
        for (int i = 1; i <= edges; i++) begin
            tick();
            if (read_valid) seen_valid++;
            if (poke && i == 99) set_wr(9'd9, 2'd1, 1, 0, 1, 1);
            if (poke && i == 100) set_wr('0, '0, 0, 0, 0, 0);
            if (i == 511) begin
                check("ready_at_511", 32'(ready), 32'd0);
                re = 1'b0;
            end
        end
        re = 1'b0;
        check("init_no_valid", 32'(seen_valid), 32'd0);
        if (edges == 512) check("ready_at_512", 32'(ready), 32'd1);
    endtask

    initial begin
        #2;
        check("rst_valid", 32'(read_valid), 32'd0);
        check("rst_ctr", 32'(counters), 32'd0);
        check("rst_pred", 32'(predict), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        tick();
        reset_n = 1'b1;
        run_init(512, 1'b1);

        rd("set0", 9'd0, 8'h55);
        rd("set255", 9'd255, 8'h55);
        rd("set511", 9'd511, 8'h55);
        rd("set9_init_upd", 9'd9, 8'h55);

        repeat (3) wr(9'd7, 2'd2, 1, 0, 1, 1);
        rd("set7_inc", 9'd7, 8'h75);
        repeat (5) wr(9'd7, 2'd2, 0, 1, 1, 1);
        rd("set7_dec", 9'd7, 8'h45);

        wr(9'd3, 2'd0, 1, 1, 1, 1);
        wr(9'd4, 2'd0, 1, 0, 1, 0);
        rd("set3_incdec", 9'd3, 8'h55);
        rd("set4_novalid", 9'd4, 8'h55);

        re = 1'b1; ridx = 9'd20;
        wr(9'd20, 2'd0, 1, 0, 1, 1);
        check_read("bypass20", 8'h56);
        ridx = 9'd21;
        wr(9'd20, 2'd1, 1, 0, 1, 1);
        check_read("indep21", 8'h55);
        re = 1'b0;
        tick();
        rd("set20_after", 9'd20, 8'h5a);

        re = 1'b1; ridx = 9'd7;
        tick();
        check_read("pre_rst", 8'h45);
        #2 reset_n = 1'b0;
        #1;
        check("rst_rdy_valid", 32'(read_valid), 32'd0);
        check("rst_rdy_ctr", 32'(counters), 32'd0);
        check("rst_rdy_ready", 32'(ready), 32'd0);
        tick();
        check("rst_hold_valid", 32'(read_valid), 32'd0);
        re = 1'b0;
        reset_n = 1'b1;
        run_init(300, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_ready", 32'(ready), 32'd0);
        check("rst_mid_valid", 32'(read_valid), 32'd0);
        tick();
        reset_n = 1'b1;
        run_init(512, 1'b0);
        rd("set7_reinit", 9'd7, 8'h55);
        rd("set20_reinit", 9'd20, 8'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
